// File: rtl/network_tx_frame_buffer.sv
// Store-and-forward TX frame buffer: a frame is released to the MAC only once its last beat is stored,
// so m_axis_tvalid never drops mid-frame. Frames that cannot fit in the buffer are discarded and counted.
module network_tx_frame_buffer #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk156,
    input  logic                  aresetn,
    input  logic [63:0]           s_axis_tdata,
    input  logic [7:0]            s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [63:0]           m_axis_tdata,
    output logic [7:0]            m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic [15:0]           frame_count,
    output logic [15:0]           drop_count,
    output logic [ADDR_WIDTH:0]   frames_stored
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int EW    = 73;

    typedef enum logic {ST_ACCEPT = 1'b0, ST_DROP = 1'b1} wr_state_t;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] ram_rd_q;

    wr_state_t     state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] wr_commit_q, wr_commit_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] fetch_ptr_q, fetch_ptr_d;
    logic          ready_en_q;
    logic          ram_valid_q, ram_valid_d;
    logic          out_valid_q, out_valid_d;
    logic [EW-1:0] out_data_q, out_data_d;
    logic [PW-1:0] frames_stored_q, frames_stored_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic [15:0]   drop_count_q, drop_count_d;

    logic [PW-1:0] occupancy;
    logic          full;
    logic          s_hs;
    logic          wr_en;
    logic          commit;
    logic          m_hs;
    logic          out_last_hs;
    logic          load_out;
    logic          fetch;

    // rd_ptr advances on the output handshake, so beats sitting in the read pipeline still
    // occupy their slots; fetch_ptr is the RAM read address running up to two beats ahead.
    assign occupancy     = wr_ptr_q - rd_ptr_q;
    assign full          = (occupancy == PW'(DEPTH));
    assign s_axis_tready = ready_en_q && ((state_q == ST_DROP) || !full);
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign wr_en         = s_hs && (state_q == ST_ACCEPT);
    assign commit        = wr_en && s_axis_tlast;
    assign m_hs          = out_valid_q && m_axis_tready;
    assign out_last_hs   = m_hs && out_data_q[EW-1];
    assign load_out      = ram_valid_q && (!out_valid_q || m_axis_tready);
    assign fetch         = (fetch_ptr_q != wr_commit_q) && (!ram_valid_q || load_out);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        wr_commit_d  = wr_commit_q;
        drop_count_d = drop_count_q;
        case (state_q)
            ST_ACCEPT: begin
                if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (s_axis_tlast) begin
                        wr_commit_d = wr_ptr_q + 1'b1;
                    end
                end else if (full && (frames_stored_q == '0)) begin
                    // The open frame fills the whole buffer and can never be committed.
                    wr_ptr_d = wr_commit_q;
                    state_d  = ST_DROP;
                end
            end
            ST_DROP: begin
                if (s_hs && s_axis_tlast) begin
                    if (drop_count_q != 16'hFFFF) begin
                        drop_count_d = drop_count_q + 1'b1;
                    end
                    state_d = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    always_comb begin
        rd_ptr_d        = rd_ptr_q + PW'(m_hs);
        fetch_ptr_d     = fetch_ptr_q + PW'(fetch);
        ram_valid_d     = ram_valid_q;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        frames_stored_d = frames_stored_q;
        frame_count_d   = frame_count_q + 16'(out_last_hs);
        if (fetch) begin
            ram_valid_d = 1'b1;
        end else if (load_out) begin
            ram_valid_d = 1'b0;
        end
        if (load_out) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_rd_q;
        end else if (m_hs) begin
            out_valid_d = 1'b0;
        end
        case ({commit, out_last_hs})
            2'b10:   frames_stored_d = frames_stored_q + 1'b1;
            2'b01:   frames_stored_d = frames_stored_q - 1'b1;
            default: frames_stored_d = frames_stored_q;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (!aresetn) begin
            state_q         <= ST_ACCEPT;
            wr_ptr_q        <= '0;
            wr_commit_q     <= '0;
            rd_ptr_q        <= '0;
            fetch_ptr_q     <= '0;
            ready_en_q      <= 1'b0;
            ram_valid_q     <= 1'b0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            frames_stored_q <= '0;
            frame_count_q   <= '0;
            drop_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            wr_commit_q     <= wr_commit_d;
            rd_ptr_q        <= rd_ptr_d;
            fetch_ptr_q     <= fetch_ptr_d;
            ready_en_q      <= 1'b1;
            ram_valid_q     <= ram_valid_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            frames_stored_q <= frames_stored_d;
            frame_count_q   <= frame_count_d;
            drop_count_q    <= drop_count_d;
        end
    end

    // Buffer storage: no reset, registered read.
    always_ff @(posedge clk156) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
        if (fetch) begin
            ram_rd_q <= mem[fetch_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    assign m_axis_tdata  = out_data_q[63:0];
    assign m_axis_tkeep  = out_data_q[71:64];
    assign m_axis_tlast  = out_data_q[72];
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tuser  = 1'b0;
    assign frame_count   = frame_count_q;
    assign drop_count    = drop_count_q;
    assign frames_stored = frames_stored_q;

endmodule

// File: tb/tb_network_tx_frame_buffer.sv
// Directed bench for network_tx_frame_buffer (ADDR_WIDTH=4): a frame table plus hand-written
// sequences for backpressure, coincident commit/release and reset in the middle of a frame.
module tb_network_tx_frame_buffer;
    localparam int AW = 4;

    logic          clk156 = 1'b0;
    logic          aresetn;
    logic [63:0]   s_tdata;
    logic [7:0]    s_tkeep;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [63:0]   m_tdata;
    logic [7:0]    m_tkeep;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tuser;
    logic          m_tready;
    logic [15:0]   frame_count;
    logic [15:0]   drop_count;
    logic [AW:0]   frames_stored;

    network_tx_frame_buffer #(.ADDR_WIDTH(AW)) dut (
        .clk156        (clk156),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .m_axis_tready (m_tready),
        .frame_count   (frame_count),
        .drop_count    (drop_count),
        .frames_stored (frames_stored)
    );

    always #5 clk156 = ~clk156;

    typedef struct {
        int         len;
        bit         gap;
        logic [7:0] keep;
        bit         pass;
    } vec_t;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            last_acc = 0;
    int            exp_frames = 0;
    int            exp_drops  = 0;
    logic [72:0]   out_q[$];
    int            rise_q[$];
    int            run_q[$];
    int            run_len  = 0;
    logic          prev_valid = 1'b0;
    int            coin_cnt = 0;
    logic          coin_pend = 1'b0;
    logic [AW:0]   fs_before = '0;
    logic [AW:0]   fs_after  = '0;

    always @(posedge clk156) cyc <= cyc + 1;

    always @(negedge clk156) begin
        if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tkeep, m_tdata});
        if (m_tvalid && !prev_valid) rise_q.push_back(cyc);
        if (m_tvalid) begin
            run_len <= run_len + 1;
        end else if (prev_valid) begin
            run_q.push_back(run_len);
            run_len <= 0;
        end
        prev_valid <= m_tvalid;
        if (coin_pend) begin
            fs_after  <= frames_stored;
            coin_pend <= 1'b0;
        end
        if (s_tvalid && s_tready && s_tlast && m_tvalid && m_tready && m_tlast) begin
            coin_cnt  <= coin_cnt + 1;
            fs_before <= frames_stored;
            coin_pend <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input int base, input int i);
        return {32'(base), 32'(i)};
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int t = 0;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        @(negedge clk156);
        while (!s_tready && t < 500) begin
            @(negedge clk156);
            t++;
        end
        if (t >= 500) chk("send_timeout", 73'(t), 73'(0));
        @(posedge clk156);
        #1;
        last_acc = cyc;
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit gap, input logic [7:0] keep, input int base);
        for (int i = 0; i < len; i++) begin
            send_beat(beat_data(base, i), (i == len - 1) ? keep : 8'hFF, i == len - 1);
            if (gap && i != len - 1) begin
                @(posedge clk156);
                #1;
            end
        end
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (out_q.size() < n && t < 1000) begin
            @(negedge clk156);
            t++;
        end
        repeat (4) @(negedge clk156);
    endtask

    task automatic check_frame(input int len, input logic [7:0] keep, input int base);
        logic [72:0] got;
        for (int i = 0; i < len; i++) begin
            got = '0;
            if (out_q.size() > 0) got = out_q.pop_front();
            chk($sformatf("beat_b%0d_i%0d", base, i), got,
                {i == len - 1, (i == len - 1) ? keep : 8'hFF, beat_data(base, i)});
        end
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_frame_count"}, 73'(frame_count), 73'(exp_frames));
        chk({tag, "_drop_count"}, 73'(drop_count), 73'(exp_drops));
        chk({tag, "_frames_stored"}, 73'(frames_stored), 73'(0));
    endtask

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        tbl[0] = '{len: 8,  gap: 1'b0, keep: 8'h0F, pass: 1'b1};
        tbl[1] = '{len: 12, gap: 1'b1, keep: 8'hFF, pass: 1'b1};
        tbl[2] = '{len: 17, gap: 1'b0, keep: 8'h01, pass: 1'b0};
        tbl[3] = '{len: 4,  gap: 1'b0, keep: 8'h3F, pass: 1'b1};
        tbl[4] = '{len: 16, gap: 1'b0, keep: 8'h07, pass: 1'b1};
        tbl[5] = '{len: 1,  gap: 1'b0, keep: 8'h01, pass: 1'b1};

        aresetn = 1'b0; m_tready = 1'b1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
        repeat (3) @(posedge clk156);
        @(negedge clk156);
        chk("rst_m_tvalid", 73'(m_tvalid), 73'(0));
        chk("rst_m_tdata", 73'(m_tdata), 73'(0));
        chk("rst_m_tkeep_tlast_tuser", 73'({m_tkeep, m_tlast, m_tuser}), 73'(0));
        chk("rst_s_tready", 73'(s_tready), 73'(0));
        check_counters("rst");
        @(posedge clk156); #1; aresetn = 1'b1;
        @(negedge clk156);
        @(negedge clk156);
        chk("post_rst_s_tready", 73'(s_tready), 73'(1));
        @(posedge clk156); #1;

        for (int r = 0; r < 6; r++) begin
            out_q.delete(); rise_q.delete(); run_q.delete();
            send_frame(tbl[r].len, tbl[r].gap, tbl[r].keep, r + 1);
            if (tbl[r].pass) begin
                exp_frames++;
                wait_beats(tbl[r].len);
                chk($sformatf("row%0d_beats", r), 73'(out_q.size()), 73'(tbl[r].len));
                v = -1;
                if (rise_q.size() > 0) v = rise_q.pop_front() - last_acc;
                chk($sformatf("row%0d_latency", r), 73'(v), 73'(2));
                v = -1;
                if (run_q.size() > 0) v = run_q.pop_front();
                chk($sformatf("row%0d_valid_run", r), 73'(v), 73'(tbl[r].len));
                check_frame(tbl[r].len, tbl[r].keep, r + 1);
            end else begin
                exp_drops++;
                repeat (20) @(negedge clk156);
                chk($sformatf("row%0d_no_output", r), 73'(out_q.size() + rise_q.size()), 73'(0));
            end
            check_counters($sformatf("row%0d", r));
            chk($sformatf("row%0d_s_tready", r), 73'(s_tready), 73'(1));
            @(posedge clk156); #1;
        end

        // Commit of frame B lands on the same edge as the tlast handshake of frame A.
        out_q.delete(); rise_q.delete(); run_q.delete();
        send_frame(4, 1'b0, 8'h03, 40);
        send_frame(6, 1'b0, 8'h07, 41);
        exp_frames += 2;
        wait_beats(10);
        chk("simul_beats", 73'(out_q.size()), 73'(10));
        check_frame(4, 8'h03, 40);
        check_frame(6, 8'h07, 41);
        chk("simul_seen", 73'(coin_cnt > 0), 73'(1));
        chk("simul_fs_before", 73'(fs_before), 73'(1));
        chk("simul_fs_unchanged", 73'(fs_after), 73'(fs_before));
        check_counters("simul");
        @(posedge clk156); #1;

        // Backpressure: two frames fill the 16-entry buffer, a third waits.
        out_q.delete(); rise_q.delete(); run_q.delete();
        m_tready = 1'b0;
        send_frame(8, 1'b0, 8'hFF, 60);
        send_frame(8, 1'b0, 8'h1F, 61);
        @(negedge clk156);
        chk("bp_s_tready_full", 73'(s_tready), 73'(0));
        chk("bp_frames_stored", 73'(frames_stored), 73'(2));
        fork
            send_frame(8, 1'b0, 8'h7F, 62);
            begin
                repeat (3) @(negedge clk156);
                chk("bp_still_blocked", 73'(s_tready), 73'(0));
                chk("bp_no_beats_yet", 73'(out_q.size()), 73'(0));
                @(posedge clk156); #1;
                m_tready = 1'b1;
            end
        join
        exp_frames += 3;
        wait_beats(24);
        chk("bp_beats", 73'(out_q.size()), 73'(24));
        check_frame(8, 8'hFF, 60);
        check_frame(8, 8'h1F, 61);
        check_frame(8, 8'h7F, 62);
        check_counters("bp");
        @(posedge clk156); #1;

        // Reset during input beat 3 of 8 while a committed frame waits at the output.
        m_tready = 1'b0;
        send_frame(4, 1'b0, 8'hFF, 50);
        repeat (4) @(negedge clk156);
        chk("prerst_m_tvalid", 73'(m_tvalid), 73'(1));
        chk("prerst_frames_stored", 73'(frames_stored), 73'(1));
        @(posedge clk156); #1;
        send_beat(beat_data(51, 0), 8'hFF, 1'b0);
        send_beat(beat_data(51, 1), 8'hFF, 1'b0);
        s_tdata = beat_data(51, 2); s_tkeep = 8'hFF; s_tlast = 1'b0; s_tvalid = 1'b1;
        aresetn = 1'b0;
        @(posedge clk156); #1;
        aresetn = 1'b1; s_tvalid = 1'b0;
        @(negedge clk156);
        exp_frames = 0; exp_drops = 0;
        chk("midrst_m_tvalid", 73'(m_tvalid), 73'(0));
        chk("midrst_m_data", 73'({m_tlast, m_tkeep, m_tdata}), 73'(0));
        chk("midrst_s_tready", 73'(s_tready), 73'(0));
        check_counters("midrst");
        @(negedge clk156);
        chk("midrst_s_tready_back", 73'(s_tready), 73'(1));
        @(posedge clk156); #1;
        out_q.delete(); rise_q.delete(); run_q.delete();
        m_tready = 1'b1;
        send_frame(4, 1'b0, 8'h1F, 52);
        exp_frames = 1;
        wait_beats(4);
        chk("postrst_beats", 73'(out_q.size()), 73'(4));
        check_frame(4, 8'h1F, 52);
        check_counters("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
